// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'h0;
  localparam opcode_t OP_ADD   = 4'h1;
  localparam opcode_t OP_SUB   = 4'h2;
  localparam opcode_t OP_AND   = 4'h3;
  localparam opcode_t OP_OR    = 4'h4;
  localparam opcode_t OP_XOR   = 4'h5;
  localparam opcode_t OP_NOT   = 4'h6;
  localparam opcode_t OP_SHL   = 4'h7;
  localparam opcode_t OP_SHR   = 4'h8;
  localparam opcode_t OP_ADC   = 4'h9;
  localparam opcode_t OP_SBC   = 4'hA;
  localparam opcode_t OP_ASR   = 4'hB;
  localparam opcode_t OP_ROL   = 4'hC;
  localparam opcode_t OP_ROR   = 4'hD;
  localparam opcode_t OP_CMP   = 4'hE;
  localparam opcode_t OP_PASSB = 4'hF;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Every opcode except NOP commits its flags and the architectural carry.
  function automatic logic op_commits(input opcode_t op);
    return (op != OP_NOP);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result, Z/N/C/V and a commit strobe for one beat.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             upd
);

  localparam int MSB = WIDTH - 1;

  logic        [WIDTH:0]   ext_sum;
  logic        [WIDTH-1:0] flag_val;
  logic signed [WIDTH-1:0] a_s;

  assign a_s = a;

  always_comb begin
    ext_sum  = '0;
    res      = '0;
    c        = 1'b0;
    v        = 1'b0;
    case (op)
      OP_NOP: res = '0;
      OP_ADD: begin
        ext_sum = {1'b0, a} + {1'b0, b};
        res     = ext_sum[MSB:0];
        c       = ext_sum[WIDTH];
        v       = (a[MSB] == b[MSB]) && (ext_sum[MSB] != a[MSB]);
      end
      OP_ADC: begin
        ext_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res     = ext_sum[MSB:0];
        c       = ext_sum[WIDTH];
        v       = (a[MSB] == b[MSB]) && (ext_sum[MSB] != a[MSB]);
      end
      // Borrow shows up in bit WIDTH, so carry is its inverse (1 = no borrow).
      OP_SUB, OP_CMP: begin
        ext_sum = {1'b0, a} - {1'b0, b};
        res     = (op == OP_CMP) ? a : ext_sum[MSB:0];
        c       = ~ext_sum[WIDTH];
        v       = (a[MSB] != b[MSB]) && (ext_sum[MSB] != a[MSB]);
      end
      OP_SBC: begin
        ext_sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ~cin};
        res     = ext_sum[MSB:0];
        c       = ~ext_sum[WIDTH];
        v       = (a[MSB] != b[MSB]) && (ext_sum[MSB] != a[MSB]);
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT:   res = ~a;
      OP_SHL: begin
        res = {a[MSB-1:0], 1'b0};
        c   = a[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a[MSB:1]};
        c   = a[0];
      end
      OP_ASR: begin
        res = a_s >>> 1;
        c   = a[0];
      end
      OP_ROL: begin
        res = {a[MSB-1:0], a[MSB]};
        c   = a[MSB];
      end
      OP_ROR: begin
        res = {a[0], a[MSB:1]};
        c   = a[0];
      end
      OP_PASSB: res = b;
    endcase
  end

  // CMP returns A but reports Z/N of the difference.
  assign flag_val = (op == OP_CMP) ? ext_sum[MSB:0] : res;
  assign z        = (flag_val == '0);
  assign n        = flag_val[MSB];
  assign upd      = op_commits(op);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 registers operands, S2 registers result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [OPW-1:0]   opS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       flags,
  output logic             carry_q
);

  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic [OPW-1:0]   op_p1_q;
  logic [WIDTH-1:0] result_p2_q, result_d;
  logic [3:0]       flags_p2_q, flags_d;
  logic             carry_d;
  logic             s1_adv, load_p1, load_p2;

  logic [WIDTH-1:0] core_res;
  logic             core_z, core_n, core_c, core_v, core_upd;

  assign s1_adv   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s1_adv;
  assign load_p1  = in_valid && in_ready;
  assign load_p2  = vld_p1_q && s1_adv;

  assign vld_p1_d = load_p1 || (vld_p1_q && !load_p2);
  assign vld_p2_d = load_p2 || (vld_p2_q && !out_ready);

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (load_p1) begin
      a_p1_q  <= opA;
      b_p1_q  <= opB;
      op_p1_q <= opS;
    end
  end

  // ---- stage 2: execute ----
  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a   (a_p1_q),
    .b   (b_p1_q),
    .op  (op_p1_q),
    .cin (carry_q),
    .res (core_res),
    .z   (core_z),
    .n   (core_n),
    .c   (core_c),
    .v   (core_v),
    .upd (core_upd)
  );

  // NOP leaves flags and carry as the previous op left them.
  always_comb begin
    result_d = core_res;
    flags_d  = flags_p2_q;
    carry_d  = carry_q;
    if (core_upd) begin
      flags_d[FLAG_Z] = core_z;
      flags_d[FLAG_N] = core_n;
      flags_d[FLAG_C] = core_c;
      flags_d[FLAG_V] = core_v;
      carry_d         = core_c;
    end
  end

  // Carry commits only on the S2 load, which keeps ADC/SBC in program order under any stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      flags_p2_q  <= '0;
      carry_q     <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (load_p2) begin
        result_p2_q <= result_d;
        flags_p2_q  <= flags_d;
        carry_q     <= carry_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign Result    = result_p2_q;
  assign flags     = flags_p2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 and WIDTH=16.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, carry_q;
  logic [7:0] opA, opB, Result;
  logic [3:0] opS, flags;

  logic        iv16, ir16, ov16, or16, cq16;
  logic [15:0] opA16, opB16, res16;
  logic [3:0]  opS16, fl16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB), .opS(opS), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .flags(flags), .carry_q(carry_q)
  );

  alu_pipe #(.WIDTH(16), .OPW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .opA(opA16), .opB(opB16), .opS(opS16), .out_valid(ov16), .out_ready(or16),
    .Result(res16), .flags(fl16), .carry_q(cq16)
  );

  // Issue one beat with out_ready high; returns on the negedge where its result is visible.
  task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; opS = op; opA = a; opB = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opA = '0; opB = '0; opS = '0;
    iv16 = 1'b0; or16 = 1'b1; opA16 = '0; opB16 = '0; opS16 = '0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (Result !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h expected 00", Result); end
    n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", carry_q); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_wrap();
    @(negedge clk);
    in_valid = 1'b1; opS = OP_ADD; opA = 8'hFF; opB = 8'h01; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_latency_early: got %b expected 0", out_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_latency: got %b expected 1", out_valid); end
    n_cmp++; if (Result !== 8'h00) begin n_err++; $display("FAIL add_wrap_res: got %h expected 00", Result); end
    n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL add_wrap_flags: got %b expected 1010", flags); end
    n_cmp++; if (carry_q !== 1'b1) begin n_err++; $display("FAIL add_wrap_carry: got %b expected 1", carry_q); end
  endtask

  task automatic test_carry_chain();
    do_op8(OP_ADD, 8'hF0, 8'h20);
    n_cmp++; if (Result !== 8'h10) begin n_err++; $display("FAIL chain_add_res: got %h expected 10", Result); end
    n_cmp++; if (carry_q !== 1'b1) begin n_err++; $display("FAIL chain_add_carry: got %b expected 1", carry_q); end
    do_op8(OP_ADC, 8'h00, 8'h00);
    n_cmp++; if (Result !== 8'h01) begin n_err++; $display("FAIL chain_adc_res: got %h expected 01", Result); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL chain_adc_flags: got %b expected 0000", flags); end
    n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL chain_adc_carry: got %b expected 0", carry_q); end
    do_op8(OP_SBC, 8'h05, 8'h01);
    n_cmp++; if (Result !== 8'h03) begin n_err++; $display("FAIL chain_sbc_res: got %h expected 03", Result); end
    n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL chain_sbc_flags: got %b expected 0010", flags); end
  endtask

  task automatic test_overflow();
    do_op8(OP_SUB, 8'h80, 8'h01);
    n_cmp++; if (Result !== 8'h7F) begin n_err++; $display("FAIL ovf_sub_res: got %h expected 7f", Result); end
    n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL ovf_sub_flags: got %b expected 0011", flags); end
    do_op8(OP_SUB, 8'h01, 8'h02);
    n_cmp++; if (Result !== 8'hFF) begin n_err++; $display("FAIL borrow_sub_res: got %h expected ff", Result); end
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL borrow_sub_flags: got %b expected 0100", flags); end
  endtask

  task automatic test_shifts();
    logic [3:0] t_op  [9];
    logic [7:0] t_a   [9];
    logic [7:0] t_b   [9];
    logic [7:0] t_res [9];
    logic [3:0] t_fl  [9];
    t_op  = '{OP_ASR, OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_XOR, OP_CMP, OP_NOP, OP_NOT};
    t_a   = '{8'h81,  8'h81,  8'h01,  8'h80,  8'h01,  8'hAA,  8'h10,  8'h33,  8'h0F};
    t_b   = '{8'h00,  8'h00,  8'h00,  8'h00,  8'h00,  8'h55,  8'h10,  8'h44,  8'h00};
    t_res = '{8'hC0,  8'h03,  8'h80,  8'h00,  8'h00,  8'hFF,  8'h10,  8'h00,  8'hF0};
    t_fl  = '{4'b0110, 4'b0010, 4'b0110, 4'b1010, 4'b1010, 4'b0100, 4'b1010, 4'b1010, 4'b0100};
    for (int i = 0; i < 9; i++) begin
      do_op8(t_op[i], t_a[i], t_b[i]);
      n_cmp++; if (Result !== t_res[i]) begin n_err++; $display("FAIL shift_res[%0d]: got %h expected %h", i, Result, t_res[i]); end
      n_cmp++; if (flags !== t_fl[i]) begin n_err++; $display("FAIL shift_flags[%0d]: got %b expected %b", i, flags, t_fl[i]); end
      if (t_op[i] == OP_NOP) begin
        n_cmp++; if (carry_q !== 1'b1) begin n_err++; $display("FAIL nop_carry_hold: got %b expected 1", carry_q); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] b_op  [4];
    logic [7:0] b_a   [4];
    logic [7:0] b_b   [4];
    logic [7:0] b_res [4];
    logic [3:0] b_fl  [4];
    b_op  = '{OP_ADD, OP_ADC, OP_ADC, OP_SBC};
    b_a   = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    b_b   = '{8'h01, 8'h00, 8'h00, 8'h00};
    b_res = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    b_fl  = '{4'b1010, 4'b0000, 4'b0100, 4'b0100};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = 1'b1; opS = b_op[c]; opA = b_a[c]; opB = b_b[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready); end
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c, out_valid); end
        n_cmp++; if (Result !== b_res[c-2]) begin n_err++; $display("FAIL b2b_res[%0d]: got %h expected %h", c, Result, b_res[c-2]); end
        n_cmp++; if (flags !== b_fl[c-2]) begin n_err++; $display("FAIL b2b_flags[%0d]: got %b expected %b", c, flags, b_fl[c-2]); end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL b2b_carry: got %b expected 0", carry_q); end
  endtask

  task automatic test_backpressure();
    logic [7:0] in_a    [6];
    logic [7:0] exp_res [6];
    int         sent, got, inflight;
    logic       prev_stall, exp_rdy;
    logic [7:0] prev_res;
    logic [3:0] prev_flags;
    in_a    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_res = '{8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67};
    sent = 0; got = 0; inflight = 0;
    prev_stall = 1'b0; prev_res = '0; prev_flags = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 6) begin
        in_valid = 1'b1; opS = OP_ADD; opA = in_a[sent]; opB = 8'h01;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
        n_cmp++; if (Result !== prev_res) begin n_err++; $display("FAIL bp_hold_res: got %h expected %h", Result, prev_res); end
        n_cmp++; if (flags !== prev_flags) begin n_err++; $display("FAIL bp_hold_flags: got %b expected %b", flags, prev_flags); end
      end
      exp_rdy = !((inflight == 2) && !out_ready);
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready[cyc %0d]: got %b expected %b", cyc, in_ready, exp_rdy); end
      if (in_valid && in_ready) begin
        sent++; inflight++;
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (Result !== exp_res[got]) begin n_err++; $display("FAIL bp_res[%0d]: got %h expected %h", got, Result, exp_res[got]); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL bp_flags[%0d]: got %b expected 0000", got, flags); end
        got++; inflight--;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = Result;
      prev_flags = flags;
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL bp_complete: got %0d beats expected 6", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup[%0d]: got %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; opS = OP_ADD; opA = 8'hFF; opB = 8'h01;
    @(negedge clk);
    opS = OP_ADD; opA = 8'h01; opB = 8'h01;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid); end
    n_cmp++; if (carry_q !== 1'b1) begin n_err++; $display("FAIL arst_pre_carry: got %b expected 1", carry_q); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL arst_carry: got %b expected 0", carry_q); end
    n_cmp++; if (Result !== 8'h00) begin n_err++; $display("FAIL arst_result: got %h expected 00", Result); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale[%0d]: got %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_width16();
    logic [15:0] w_a   [2];
    logic [15:0] w_res [2];
    logic [3:0]  w_fl  [2];
    logic        w_c   [2];
    w_a   = '{16'hFFFF, 16'h7FFF};
    w_res = '{16'h0000, 16'h8000};
    w_fl  = '{4'b1010, 4'b0101};
    w_c   = '{1'b1, 1'b0};
    or16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      iv16 = 1'b1; opS16 = OP_ADD; opA16 = w_a[i]; opB16 = 16'h0001;
      #1;
      n_cmp++; if (ir16 !== 1'b1) begin n_err++; $display("FAIL w16_in_ready[%0d]: got %b expected 1", i, ir16); end
      @(negedge clk);
      iv16 = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++; if (ov16 !== 1'b1) begin n_err++; $display("FAIL w16_valid[%0d]: got %b expected 1", i, ov16); end
      n_cmp++; if (res16 !== w_res[i]) begin n_err++; $display("FAIL w16_res[%0d]: got %h expected %h", i, res16, w_res[i]); end
      n_cmp++; if (fl16 !== w_fl[i]) begin n_err++; $display("FAIL w16_flags[%0d]: got %b expected %b", i, fl16, w_fl[i]); end
      n_cmp++; if (cq16 !== w_c[i]) begin n_err++; $display("FAIL w16_carry[%0d]: got %b expected %b", i, cq16, w_c[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_carry_chain();
    test_overflow();
    test_shifts();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational ALU: WIDTH-bit operands, 4-bit opcode, registered result and status flags.
- Two-stage pipeline with valid/ready handshakes on both sides, so it sits between an operand-issue unit and a result-writeback unit.
- Adds behaviour the combinational ALU lacks: carry chaining through a stored carry flag (ADC/SBC), Z/N/C/V flags, arithmetic shift, rotates, compare and backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 4..64.
- OPW, 4, opcode width; fixed at 4 and must not be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode beat present.
- in_ready  out  1  block accepts a beat this cycle.
- opA  in  WIDTH  operand A.
- opB  in  WIDTH  operand B.
- opS  in  OPW  opcode.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts a result beat.
- Result  out  WIDTH  result.
- flags  out  4  {Z,N,C,V} belonging to the Result beat.
- carry_q  out  1  architectural carry flag, for debug.

Behaviour:
- Reset (async assert, sync-safe deassert): both stage valids = 0, out_valid = 0, Result = 0, flags = 0, carry_q = 0. in_ready = 1 in the first cycle after reset.
- Stage 1 (S1) registers opA, opB and opS.
  - S1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready.
- Stage 2 (S2) computes from S1 and registers Result and flags.
  - S2 loads when s1_valid && s1_adv.
  - s2_valid clears on out_ready when there is no new load.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput: 1 beat per cycle.
- Stall rule: while out_valid && !out_ready, Result and flags hold stable. At most 2 beats are in flight. No beat is dropped or duplicated.
- Opcodes. Shifts operate on A; SHL and SHR shift by one bit.
  - 0 NOP: Result = 0, flags unchanged, carry_q unchanged.
  - 1 ADD: A+B.
  - 2 SUB: A-B.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT: ~A.
  - 7 SHL: A<<1, C = A[MSB].
  - 8 SHR: logical right shift, C = A[0].
  - 9 ADC: A+B+carry_q.
  - 10 SBC: A-B-!carry_q.
  - 11 ASR: arithmetic right shift, C = A[0].
  - 12 ROL.
  - 13 ROR.
  - 14 CMP: flags as for SUB, Result = A.
  - 15 PASSB: Result = B.
- Arithmetic width rules: compute in WIDTH+1 bits.
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBC/CMP: C = 1 means no borrow (A >= B for SUB).
  - V: signed overflow for arithmetic ops; V = 0 for all other ops.
  - Z = (Result == 0). N = Result[MSB].
- Logic ops and PASSB: C = 0. ROL/ROR: C = the bit rotated across.
- Flag timing: carry_q updates at the S2 load of every non-NOP op, in program order. ADC/SBC therefore always see the carry from the immediately preceding non-NOP op. This holds under any stall pattern, so no hazard logic is needed.
- Reset mid-operation: in-flight beats are discarded, carry_q = 0, and no out_valid is issued for them.
- Simultaneous in and out handshakes while the pipeline is full: sustain one beat per cycle.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_NOP..OP_PASSB (4'h0..4'hF);
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, alu_core(WIDTH): inputs a, b, op, cin; outputs res, z, n, c, v, upd. It is instantiated in S2.
- The pipeline and handshake logic stay in alu_pipe.

Test Plan:
- Reset, then WIDTH=8: ADD 8'hFF+8'h01 -> after 2 cycles Result=8'h00, flags Z=1, N=0, C=1, V=0.
- Carry chain: ADD 8'hF0+8'h20, then ADC 8'h00+8'h00 -> second Result=8'h01. SBC 8'h05-8'h01 with carry_q=0 -> Result=8'h03.
- Overflow: SUB 8'h80-8'h01 -> Result=8'h7F, V=1, C=1, N=0.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,... -> all 6 results in order, values held while stalled, in_ready=0 exactly when both stages are full and out_ready=0.
- Shifts and rotates: ASR 8'h81 -> 8'hC0, C=1; ROL 8'h81 -> 8'h03, C=1; CMP 8'h10 vs 8'h10 -> Result=8'h10, Z=1.
- Async reset asserted with 2 beats in flight -> out_valid=0 immediately, carry_q=0, and no stale beat after release. Repeat the run at WIDTH=16 with ADD 16'hFFFF+1 -> Z=1, C=1.
